// File: rtl/ch0_burst_tx.sv
// Channel-0 ultrasonic transmit burst generator, Avalon-MM slave.
// Optional IRQ output and mask bit are enabled by defining CH0_BURST_TX_IRQ_EN.
module ch0_burst_tx #(
    parameter int          HP_W      = 16,
    parameter int          CNT_W     = 8,
    parameter int unsigned HP_RESET  = 625,
    parameter int unsigned CNT_RESET = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_out,
`ifdef CH0_BURST_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

`ifdef CH0_BURST_TX_IRQ_EN
    localparam int ABORT_BIT = 3;
`else
    localparam int ABORT_BIT = 2;
`endif

    state_t             state_q, state_d;
    logic [HP_W-1:0]    hp_q, hp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HP_W-1:0]    hpw_q, hpw_d;
    logic [CNT_W-1:0]   cntw_q, cntw_d;
    logic [HP_W-1:0]    tmr_q, tmr_d;
    logic               done_q, done_d;
    logic               irq_mask_q, irq_mask_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_set;

    logic               wr, ctrl_wr, start, abort;
    logic [HP_W-1:0]    hp_eff;
    logic               unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign ctrl_wr = wr && (address == 2'd0);
    assign start   = ctrl_wr & writedata[0];
    assign abort   = ctrl_wr & writedata[ABORT_BIT];
    // A programmed half-period of zero behaves as one cycle.
    assign hp_eff  = (hp_q == '0) ? HP_W'(1) : hp_q;
    assign unused_wdata = ^writedata;

    assign tx_out   = (state_q == HIGH);
    assign busy     = (state_q != IDLE);
    assign readdata = rdata_q;

`ifdef CH0_BURST_TX_IRQ_EN
    assign irq = done_q & irq_mask_q;
`endif

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        cnt_d      = cnt_q;
        hpw_d      = hpw_q;
        cntw_d     = cntw_q;
        tmr_d      = tmr_q;
        done_d     = done_q;
        irq_mask_d = irq_mask_q;
        done_set   = 1'b0;

        if (wr && address == 2'd1) hp_d  = writedata[HP_W-1:0];
        if (wr && address == 2'd2) cnt_d = writedata[CNT_W-1:0];
`ifdef CH0_BURST_TX_IRQ_EN
        if (ctrl_wr) irq_mask_d = writedata[2];
`endif

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cnt_q == '0) begin
                            done_set = 1'b1;
                        end else begin
                            state_d = HIGH;
                            hpw_d   = hp_eff;
                            cntw_d  = cnt_q;
                            tmr_d   = hp_eff - 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (tmr_q == '0) begin
                        state_d = LOW;
                        tmr_d   = hpw_q - 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                LOW: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (cntw_q == CNT_W'(1)) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = HIGH;
                        cntw_d  = cntw_q - 1'b1;
                        tmr_d   = hpw_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Completion beats a coincident DONE clear.
        if (wr && address == 2'd3) done_d = 1'b0;
        if (done_set)              done_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        unique case (address)
            2'd0:    rdata_d = {29'd0, irq_mask_q, tx_out, busy};
            2'd1:    rdata_d = 32'(hp_q);
            2'd2:    rdata_d = 32'(cnt_q);
            default: rdata_d = {31'd0, done_q};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            hp_q       <= HP_W'(HP_RESET);
            cnt_q      <= CNT_W'(CNT_RESET);
            hpw_q      <= '0;
            cntw_q     <= '0;
            tmr_q      <= '0;
            done_q     <= 1'b0;
            irq_mask_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            cnt_q      <= cnt_d;
            hpw_q      <= hpw_d;
            cntw_q     <= cntw_d;
            tmr_q      <= tmr_d;
            done_q     <= done_d;
            irq_mask_q <= irq_mask_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ch0_burst_tx.sv
// Directed self-checking bench for ch0_burst_tx (default build, no IRQ).
module tb_ch0_burst_tx;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    ch0_burst_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle, entered and left on a falling edge; DUT captures on the rising edge between.
    task automatic bus_cycle(input logic we, input logic [1:0] a, input logic [31:0] d);
        chipselect = we;
        write_n    = ~we;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_cycle(1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus_cycle(1'b0, a, 32'd0);
        v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
        #12;
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL reset_tx: got %b want 0", tx_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %0d want 0", readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd1, v);
        n_cmp++; if (v !== 32'd625) begin n_err++; $display("FAIL reset_hp: got %0d want 625", v); end
        rd(2'd2, v);
        n_cmp++; if (v !== 32'd8) begin n_err++; $display("FAIL reset_cnt: got %0d want 8", v); end
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_done: got %0d want 0", v); end
        rd(2'd0, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %0d want 0", v); end
    endtask

    task automatic test_basic_burst();
        logic [12:0] exp_tx;
        logic [31:0] v;
        exp_tx = 13'b1110001110000;
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 13; i++) begin
            n_cmp++;
            if (tx_out !== exp_tx[12-i]) begin
                n_err++; $display("FAIL basic_tx[%0d]: got %b want %b", i, tx_out, exp_tx[12-i]);
            end
            n_cmp++;
            if (busy !== (i < 12)) begin
                n_err++; $display("FAIL basic_busy[%0d]: got %b want %b", i, busy, (i < 12));
            end
            @(negedge clk);
        end
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL basic_done: got %0d want 1", v); end
        wr(2'd3, 32'd0);
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL basic_done_clr: got %0d want 0", v); end
    endtask

    task automatic test_hp_zero();
        logic [2:0] exp_tx, exp_busy;
        exp_tx   = 3'b100;
        exp_busy = 3'b110;
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (tx_out !== exp_tx[2-i]) begin
                n_err++; $display("FAIL hp0_tx[%0d]: got %b want %b", i, tx_out, exp_tx[2-i]);
            end
            n_cmp++;
            if (busy !== exp_busy[2-i]) begin
                n_err++; $display("FAIL hp0_busy[%0d]: got %b want %b", i, busy, exp_busy[2-i]);
            end
            @(negedge clk);
        end
        wr(2'd3, 32'd0);
    endtask

    task automatic test_cnt_zero();
        logic [31:0] v;
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd1);
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL cnt0_tx: got %b want 0", tx_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cnt0_busy: got %b want 0", busy); end
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL cnt0_done: got %0d want 1", v); end
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL cnt0_tx_late: got %b want 0", tx_out); end
        wr(2'd3, 32'd0);
    endtask

    task automatic test_reprogram_during_burst();
        int n;
        logic [31:0] v;
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd5);
        wr(2'd0, 32'd1);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            n++;
            if (c == 6)      bus_cycle(1'b1, 2'd1, 32'd10);
            else if (c == 7) bus_cycle(1'b1, 2'd0, 32'd1);
            else             bus_cycle(1'b0, 2'd0, 32'd0);
        end
        n_cmp++; if (n !== 40) begin n_err++; $display("FAIL reprog_busy_len: got %0d want 40", n); end
        rd(2'd1, v);
        n_cmp++; if (v !== 32'd10) begin n_err++; $display("FAIL reprog_hp: got %0d want 10", v); end
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        n_cmp++; if (n !== 20) begin n_err++; $display("FAIL reprog_next_len: got %0d want 20", n); end
        wr(2'd3, 32'd0);
    endtask

    task automatic test_abort();
        logic [31:0] v;
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd1);
        bus_cycle(1'b0, 2'd0, 32'd0);
        n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL abort_pre_tx: got %b want 1", tx_out); end
        wr(2'd0, 32'd4);
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL abort_tx: got %b want 0", tx_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (15) @(negedge clk);
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL abort_done: got %0d want 0", v); end
        // Start and abort in the same write: abort wins, nothing launches.
        wr(2'd0, 32'd5);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_prio_busy: got %b want 0", busy); end
    endtask

    task automatic test_done_clear_race();
        logic [31:0] v;
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd1);
        bus_cycle(1'b0, 2'd0, 32'd0);
        wr(2'd3, 32'd0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL race_busy: got %b want 0", busy); end
        rd(2'd3, v);
        n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL race_done: got %0d want 1", v); end
        wr(2'd3, 32'd0);
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        wr(2'd1, 32'd5);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        bus_cycle(1'b0, 2'd0, 32'd0);
        n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL arst_pre_tx: got %b want 1", tx_out); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL arst_tx: got %b want 0", tx_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1, v);
        n_cmp++; if (v !== 32'd625) begin n_err++; $display("FAIL arst_hp: got %0d want 625", v); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_hp_zero();
        test_cnt_zero();
        test_reprogram_during_burst();
        test_abort();
        test_done_clear_race();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
